rx_arp: RTL and testbench

- Consumes the payload byte stream produced by rx_ethernet: the bytes following the 14-byte Ethernet header, with FCS excluded.
- Processes only frames whose EtherType is ARP (0x0806). Parses the 28-byte ARP body.
- On a valid ARP request addressed to our IP, it raises a one-cycle reply-request pulse. It also latches the sender MAC/IP for the TX path and for the CSR readback.
- Runs in parallel with rx_ipv4 on the same rx_ethernet_data stream.

---
 rtl/vthernet_pkg.sv | 30 +++
 rtl/rx_arp.sv | 84 ++++++++
 tb/tb_rx_arp.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/vthernet_pkg.sv
// vthernet_pkg: shared constants, ARP field offsets and rx_arp state encoding
package vthernet_pkg;
   localparam int OCT = 8;
   localparam logic [15:0] ARP_TYPE      = 16'h0806;
   localparam logic [15:0] IPV4          = 16'h0800;
   localparam logic [15:0] ARP_HTYPE_ETH = 16'h0001;
   localparam logic [15:0] ARP_OPER_REQ  = 16'h0001;
   localparam logic [15:0] ARP_OPER_REP  = 16'h0002;
   localparam logic [7:0]  ARP_HLEN      = 8'd6;
   localparam logic [7:0]  ARP_PLEN      = 8'd4;
   localparam logic [4:0]  OFF_OPER = 5'd6;
   localparam logic [4:0]  OFF_SHA  = 5'd8;
   localparam logic [4:0]  OFF_SPA  = 5'd14;
   localparam logic [4:0]  OFF_THA  = 5'd18;
   localparam logic [4:0]  OFF_TPA  = 5'd24;
   localparam logic [4:0]  ARP_LEN  = 5'd28;
   localparam logic [4:0]  ARP_LAST = ARP_LEN - 5'd1;
   localparam logic [1:0]  S_IDLE   = 2'd0;
   localparam logic [1:0]  S_PARSE  = 2'd1;
   localparam logic [1:0]  S_DRAIN  = 2'd2;
   localparam logic [1:0]  S_DECIDE = 2'd3;
   // expected value of fixed header bytes 0..5 (HTYPE, PTYPE, HLEN, PLEN)
   function automatic logic [7:0] hdr_exp(input logic [4:0] idx);
      return idx == 5'd0 ? ARP_HTYPE_ETH[15:8] :
             idx == 5'd1 ? ARP_HTYPE_ETH[7:0]  :
             idx == 5'd2 ? IPV4[15:8]          :
             idx == 5'd3 ? IPV4[7:0]           :
             idx == 5'd4 ? ARP_HLEN            : ARP_PLEN;
   endfunction
endpackage

// File: rtl/rx_arp.sv
// rx_arp: parses ARP payloads from rx_ethernet and flags requests/replies for our IP
module rx_arp import vthernet_pkg::*; (
   input  logic           RX_CLK,
   input  logic           rst,
   input  logic           func_en,
   input  logic [31:0]    ip_addr,
   input  logic [15:0]    rx_len_type,
   input  logic           rx_ethernet_data_v,
   input  logic [OCT-1:0] rx_ethernet_data,
   output logic           arp_req_v,
   output logic           arp_reply_rx,
   output logic           arp_err,
   output logic [47:0]    arp_sender_mac,
   output logic [31:0]    arp_sender_ip,
   output logic           rx_arp_irq
);
   logic [1:0]  state;
   logic [4:0]  cnt, idx;
   logic        dv_q, mism, tpa_ok, full, req_q, rep_q, err_q;
   logic        idle_like, start, take, trunc, decide_now, accept;
   logic [15:0] oper;
   logic [47:0] sha_sh;
   logic [31:0] spa_sh;
   logic [7:0]  ip_b;
   // DECIDE behaves like IDLE for frame starts so a back-to-back byte 0 is not lost;
   // dv_q blocks a start when reset releases in the middle of a frame
   assign idle_like  = state == S_IDLE || state == S_DECIDE;
   assign start      = idle_like && rx_ethernet_data_v && !dv_q && func_en && rx_len_type == ARP_TYPE;
   assign take       = start || (state == S_PARSE && rx_ethernet_data_v);
   assign idx        = state == S_PARSE ? cnt : 5'd0;
   assign ip_b       = idx[1:0] == 2'd0 ? ip_addr[31:24] : idx[1:0] == 2'd1 ? ip_addr[23:16] :
                       idx[1:0] == 2'd2 ? ip_addr[15:8] : ip_addr[7:0];
   assign trunc      = !rst && state == S_PARSE && !rx_ethernet_data_v;
   assign decide_now = state == S_DRAIN && !rx_ethernet_data_v && full;
   assign accept     = decide_now && !mism && tpa_ok && (oper == ARP_OPER_REQ || oper == ARP_OPER_REP);
   assign arp_req_v    = req_q;
   assign arp_reply_rx = rep_q;
   assign arp_err      = err_q | trunc;
   assign rx_arp_irq   = req_q | rep_q;
   // frame FSM, field capture and the decision registered into the DECIDE cycle
   always_ff @(posedge RX_CLK) begin
      if (rst) begin
         state          <= S_IDLE;
         cnt            <= '0;
         dv_q           <= 1'b1;
         mism           <= 1'b0;
         tpa_ok         <= 1'b0;
         full           <= 1'b0;
         oper           <= '0;
         sha_sh         <= '0;
         spa_sh         <= '0;
         req_q          <= 1'b0;
         rep_q          <= 1'b0;
         err_q          <= 1'b0;
         arp_sender_mac <= '0;
         arp_sender_ip  <= '0;
      end else begin
         dv_q  <= rx_ethernet_data_v;
         req_q <= accept && oper == ARP_OPER_REQ;
         rep_q <= accept && oper == ARP_OPER_REP;
         err_q <= decide_now && (mism || (oper != ARP_OPER_REQ && oper != ARP_OPER_REP));
         if (accept) begin
            arp_sender_mac <= sha_sh;
            arp_sender_ip  <= spa_sh;
         end
         if (idle_like) full <= 1'b0;
         if (take) begin
            cnt    <= idx + 5'd1;
            full   <= idx == ARP_LAST;
            mism   <= (start ? 1'b0 : mism) | (idx < OFF_OPER && rx_ethernet_data != hdr_exp(idx));
            tpa_ok <= (start ? 1'b1 : tpa_ok) & (idx < OFF_TPA || rx_ethernet_data == ip_b);
            if (idx >= OFF_OPER && idx < OFF_SHA) oper   <= {oper[7:0], rx_ethernet_data};
            if (idx >= OFF_SHA && idx < OFF_SPA)  sha_sh <= {sha_sh[39:0], rx_ethernet_data};
            if (idx >= OFF_SPA && idx < OFF_THA)  spa_sh <= {spa_sh[23:0], rx_ethernet_data};
         end
         if (idle_like)
            state <= start ? S_PARSE : rx_ethernet_data_v ? S_DRAIN : S_IDLE;
         else if (state == S_PARSE)
            state <= !rx_ethernet_data_v ? S_IDLE : idx == ARP_LAST ? S_DRAIN : S_PARSE;
         else
            state <= rx_ethernet_data_v ? S_DRAIN : full ? S_DECIDE : S_IDLE;
      end
   end
endmodule

// File: tb/tb_rx_arp.sv
// tb_rx_arp: directed self-checking bench for rx_arp
module tb_rx_arp;
   logic        RX_CLK = 1'b0;
   logic        rst = 1'b1;
   logic        func_en = 1'b1;
   logic [31:0] ip_addr = 32'hC0A8_0164;
   logic [15:0] rx_len_type = 16'h0806;
   logic        dv = 1'b0;
   logic [7:0]  data = 8'h00;
   logic        arp_req_v, arp_reply_rx, arp_err, rx_arp_irq;
   logic [47:0] arp_sender_mac;
   logic [31:0] arp_sender_ip;
   int checks = 0, errors = 0;
   int n_req, n_rep, n_err, n_irq, first_at, multi, irq_bad, rst_at = -1;
   logic [7:0]  frm [0:63];
   logic [47:0] mac_log [0:3];

   rx_arp dut (
      .RX_CLK(RX_CLK), .rst(rst), .func_en(func_en), .ip_addr(ip_addr),
      .rx_len_type(rx_len_type), .rx_ethernet_data_v(dv), .rx_ethernet_data(data),
      .arp_req_v(arp_req_v), .arp_reply_rx(arp_reply_rx), .arp_err(arp_err),
      .arp_sender_mac(arp_sender_mac), .arp_sender_ip(arp_sender_ip), .rx_arp_irq(rx_arp_irq)
   );

   always #5 RX_CLK = ~RX_CLK;

   task automatic build(input logic [15:0] oper, input logic [47:0] sha, input logic [31:0] tpa, input logic [7:0] hlen);
      for (int k = 0; k < 64; k++) frm[k] = 8'h00;
      frm[0] = 8'h00; frm[1] = 8'h01; frm[2] = 8'h08; frm[3] = 8'h00;
      frm[4] = hlen;  frm[5] = 8'h04; frm[6] = oper[15:8]; frm[7] = oper[7:0];
      for (int k = 0; k < 6; k++) frm[8 + k] = sha[47 - 8 * k -: 8];
      frm[14] = 8'hC0; frm[15] = 8'hA8; frm[16] = 8'h01; frm[17] = 8'h01;
      for (int k = 0; k < 4; k++) frm[24 + k] = tpa[31 - 8 * k -: 8];
   endtask

   // drives n payload bytes then tail idle cycles; first_at is relative to the first idle cycle
   task automatic run_frame(input int n, input int tail);
      n_req = 0; n_rep = 0; n_err = 0; n_irq = 0; multi = 0; irq_bad = 0; first_at = -99;
      for (int i = 0; i < n + tail; i++) begin
         @(posedge RX_CLK); #1;
         dv = i < n;
         data = i < n ? frm[i] : 8'h00;
         rst = i == rst_at;
         @(negedge RX_CLK);
         if ((arp_req_v | arp_reply_rx | arp_err) && first_at == -99) first_at = i - n;
         if (arp_req_v && n_req < 4) mac_log[n_req] = arp_sender_mac;
         n_req += int'(arp_req_v); n_rep += int'(arp_reply_rx); n_err += int'(arp_err); n_irq += int'(rx_arp_irq);
         if (int'(arp_req_v) + int'(arp_reply_rx) + int'(arp_err) > 1) multi++;
         if (rx_arp_irq !== (arp_req_v | arp_reply_rx)) irq_bad++;
      end
      rst = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (3) @(posedge RX_CLK);
      @(negedge RX_CLK);
      checks++; if (arp_req_v !== 1'b0) begin errors++; $display("FAIL reset_req got %b want 0", arp_req_v); end
      checks++; if (arp_reply_rx !== 1'b0) begin errors++; $display("FAIL reset_rep got %b want 0", arp_reply_rx); end
      checks++; if (arp_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", arp_err); end
      checks++; if (rx_arp_irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %b want 0", rx_arp_irq); end
      checks++; if (arp_sender_mac !== 48'h0) begin errors++; $display("FAIL reset_mac got %h want 0", arp_sender_mac); end
      checks++; if (arp_sender_ip !== 32'h0) begin errors++; $display("FAIL reset_ip got %h want 0", arp_sender_ip); end
      @(posedge RX_CLK); #1; rst = 1'b0;
      repeat (2) @(posedge RX_CLK);
   endtask

   task automatic test_request;
      build(16'h0001, 48'h0200_0000_0001, 32'hC0A8_0164, 8'h06);
      run_frame(46, 3);
      checks++; if (n_req !== 1) begin errors++; $display("FAIL req_count got %0d want 1", n_req); end
      checks++; if (first_at !== 1) begin errors++; $display("FAIL req_latency got %0d want 1", first_at); end
      checks++; if (n_err + n_rep !== 0) begin errors++; $display("FAIL req_other got %0d want 0", n_err + n_rep); end
      checks++; if (n_irq !== 1 || irq_bad !== 0) begin errors++; $display("FAIL req_irq got %0d/%0d want 1/0", n_irq, irq_bad); end
      checks++; if (arp_sender_mac !== 48'h0200_0000_0001) begin errors++; $display("FAIL req_mac got %h want 020000000001", arp_sender_mac); end
      checks++; if (arp_sender_ip !== 32'hC0A8_0101) begin errors++; $display("FAIL req_ip got %h want c0a80101", arp_sender_ip); end
   endtask

   task automatic test_wrong_tpa;
      build(16'h0001, 48'h0200_0000_0099, 32'hC0A8_0165, 8'h06);
      run_frame(46, 3);
      checks++; if (n_req + n_rep + n_err !== 0) begin errors++; $display("FAIL tpa_pulses got %0d want 0", n_req + n_rep + n_err); end
      checks++; if (arp_sender_mac !== 48'h0200_0000_0001) begin errors++; $display("FAIL tpa_mac got %h want 020000000001", arp_sender_mac); end
   endtask

   task automatic test_reply;
      build(16'h0002, 48'h0200_0000_0002, 32'hC0A8_0164, 8'h06);
      run_frame(46, 3);
      checks++; if (n_rep !== 1 || first_at !== 1) begin errors++; $display("FAIL rep_pulse got %0d@%0d want 1@1", n_rep, first_at); end
      checks++; if (n_req !== 0 || n_err !== 0) begin errors++; $display("FAIL rep_other got %0d/%0d want 0/0", n_req, n_err); end
      checks++; if (n_irq !== 1 || irq_bad !== 0) begin errors++; $display("FAIL rep_irq got %0d/%0d want 1/0", n_irq, irq_bad); end
      checks++; if (arp_sender_mac !== 48'h0200_0000_0002) begin errors++; $display("FAIL rep_mac got %h want 020000000002", arp_sender_mac); end
   endtask

   task automatic test_errors;
      build(16'h0001, 48'h0200_0000_0003, 32'hC0A8_0164, 8'h08);
      run_frame(46, 3);
      checks++; if (n_err !== 1 || first_at !== 1 || n_req !== 0) begin errors++; $display("FAIL hlen_err got %0d@%0d req %0d want 1@1 req 0", n_err, first_at, n_req); end
      build(16'h0001, 48'h0200_0000_0004, 32'hC0A8_0164, 8'h06);
      run_frame(20, 3);
      checks++; if (n_err !== 1 || first_at !== 0 || n_req !== 0) begin errors++; $display("FAIL trunc_err got %0d@%0d req %0d want 1@0 req 0", n_err, first_at, n_req); end
      build(16'h0003, 48'h0200_0000_0005, 32'hC0A8_0164, 8'h06);
      run_frame(46, 3);
      checks++; if (n_err !== 1 || first_at !== 1 || n_req + n_rep !== 0) begin errors++; $display("FAIL oper_err got %0d@%0d want 1@1", n_err, first_at); end
      checks++; if (arp_sender_mac !== 48'h0200_0000_0002) begin errors++; $display("FAIL err_mac got %h want 020000000002", arp_sender_mac); end
      checks++; if (multi !== 0) begin errors++; $display("FAIL err_exclusive got %0d want 0", multi); end
   endtask

   task automatic test_filtered;
      build(16'h0001, 48'h0200_0000_0006, 32'hC0A8_0164, 8'h06);
      rx_len_type = 16'h0800;
      run_frame(46, 3);
      checks++; if (n_req + n_rep + n_err !== 0) begin errors++; $display("FAIL ipv4_type got %0d want 0", n_req + n_rep + n_err); end
      rx_len_type = 16'h0806; func_en = 1'b0;
      run_frame(46, 3);
      checks++; if (n_req + n_rep + n_err !== 0) begin errors++; $display("FAIL func_dis got %0d want 0", n_req + n_rep + n_err); end
      func_en = 1'b1;
      checks++; if (arp_sender_mac !== 48'h0200_0000_0002) begin errors++; $display("FAIL filt_mac got %h want 020000000002", arp_sender_mac); end
   endtask

   task automatic test_exact_len;
      build(16'h0001, 48'h0200_0000_0007, 32'hC0A8_0164, 8'h06);
      run_frame(28, 3);
      checks++; if (n_req !== 1 || first_at !== 1) begin errors++; $display("FAIL len28 got %0d@%0d want 1@1", n_req, first_at); end
      checks++; if (arp_sender_mac !== 48'h0200_0000_0007) begin errors++; $display("FAIL len28_mac got %h want 020000000007", arp_sender_mac); end
   endtask

   task automatic test_back_to_back;
      build(16'h0001, 48'h0200_0000_000A, 32'hC0A8_0164, 8'h06);
      run_frame(46, 1);
      checks++; if (n_req !== 0) begin errors++; $display("FAIL b2b_early got %0d want 0", n_req); end
      build(16'h0001, 48'h0200_0000_000B, 32'hC0A8_0164, 8'h06);
      run_frame(46, 3);
      checks++; if (n_req !== 2) begin errors++; $display("FAIL b2b_count got %0d want 2", n_req); end
      checks++; if (mac_log[0] !== 48'h0200_0000_000A) begin errors++; $display("FAIL b2b_mac0 got %h want 02000000000a", mac_log[0]); end
      checks++; if (mac_log[1] !== 48'h0200_0000_000B) begin errors++; $display("FAIL b2b_mac1 got %h want 02000000000b", mac_log[1]); end
   endtask

   task automatic test_rst_mid;
      build(16'h0001, 48'h0200_0000_000C, 32'hC0A8_0164, 8'h06);
      run_frame(46, 1);
      build(16'h0001, 48'h0200_0000_000D, 32'hC0A8_0164, 8'h06);
      rst_at = 10;
      run_frame(46, 3);
      rst_at = -1;
      checks++; if (n_req !== 1 || mac_log[0] !== 48'h0200_0000_000C) begin errors++; $display("FAIL rst_first got %0d %h want 1 02000000000c", n_req, mac_log[0]); end
      checks++; if (arp_sender_mac !== 48'h0 || arp_sender_ip !== 32'h0) begin errors++; $display("FAIL rst_clear got %h %h want 0 0", arp_sender_mac, arp_sender_ip); end
      checks++; if (n_err + n_rep !== 0) begin errors++; $display("FAIL rst_other got %0d want 0", n_err + n_rep); end
      build(16'h0001, 48'h0200_0000_000E, 32'hC0A8_0164, 8'h06);
      run_frame(46, 3);
      checks++; if (n_req !== 1 || arp_sender_mac !== 48'h0200_0000_000E) begin errors++; $display("FAIL rst_recover got %0d %h want 1 02000000000e", n_req, arp_sender_mac); end
   endtask

   initial begin
      test_reset;
      test_request;
      test_wrong_tpa;
      test_reply;
      test_errors;
      test_filtered;
      test_exact_len;
      test_back_to_back;
      test_rst_mid;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
